fan_speed_sequencer: RTL and testbench

FAN_SPEED_SEQUENCER -- requirements
Module: fan_speed_sequencer

---
 rtl/fan_ctrl_pkg.sv | 55 +++++
 rtl/tach_counter.sv | 50 +++++
 rtl/fan_speed_sequencer.sv | 152 +++++++++++++++
 tb/tb_fan_speed_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_ctrl_pkg.sv
// Shared definitions for the fan speed sequencer: FSM encoding, level type,
// default thresholds/divider values and the thermal level stepping rule.
package fan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_SPINUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_STALL  = 2'd2
    } fan_state_t;

    localparam int unsigned NUM_LEVELS = 4;
    localparam int unsigned LEVEL_W    = 2;
    localparam int unsigned TACH_CNT_W = 8;

    typedef logic [LEVEL_W-1:0] level_t;

    localparam logic [11:0] DEF_T1   = 12'h900;
    localparam logic [11:0] DEF_T2   = 12'hA00;
    localparam logic [11:0] DEF_T3   = 12'hB00;
    localparam int unsigned DEF_HYST = 16;

    localparam logic [31:0] DEF_DIV0 = 32'd5000;
    localparam logic [31:0] DEF_DIV1 = 32'd2500;
    localparam logic [31:0] DEF_DIV2 = 32'd1250;
    localparam logic [31:0] DEF_DIV3 = 32'd0;

    // One step per sample: up when the next threshold is reached, down only once the
    // sample plus hysteresis falls below the current level's threshold (13-bit sum).
    function automatic level_t step_level(
        input level_t      level,
        input logic [11:0] temp,
        input logic [11:0] t1,
        input logic [11:0] t2,
        input logic [11:0] t3,
        input logic [12:0] hyst
    );
        logic [11:0] t_up;
        logic [11:0] t_dn;
        logic [12:0] temp_hyst;
        case (level)
            2'd0:    begin t_up = t1; t_dn = t1; end
            2'd1:    begin t_up = t2; t_dn = t1; end
            2'd2:    begin t_up = t3; t_dn = t2; end
            default: begin t_up = t3; t_dn = t3; end
        endcase
        temp_hyst = {1'b0, temp} + hyst;
        if (level != 2'd3 && temp >= t_up) begin
            return level + 2'd1;
        end else if (level != 2'd0 && temp_hyst < {1'b0, t_dn}) begin
            return level - 2'd1;
        end
        return level;
    endfunction

endpackage

// File: rtl/tach_counter.sv
// Tachometer input synchronizer with a saturating rising-edge counter.
// A clear that coincides with an edge starts the new count at one, so no edge is lost.
module tach_counter
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = TACH_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             i_tach,
    input  logic             i_enable,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_count;
    logic             w_edge;

    assign w_edge = r_sync2 & ~r_prev & i_enable;

    // NOTE: non-blocking assignments keep the three flops a true shift chain; blocking
    // would collapse the synchronizer into a single stage.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_tach;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= {{(CNT_W-1){1'b0}}, w_edge};
        end else if (w_edge && r_count != {CNT_W{1'b1}}) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fan_speed_sequencer.sv
// Fan speed sequencer: thermal level tracking, spin-up / run / stall supervision and
// the registered divider value (with load strobe) for the downstream clock divider.
module fan_speed_sequencer
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned SPINUP_CYCLES = 1_000_000,
    parameter int unsigned TACH_WINDOW   = 10_000_000,
    parameter int unsigned TACH_MIN      = 2,
    parameter int unsigned STALL_CYCLES  = 50_000_000,
    parameter logic [11:0] T1            = DEF_T1,
    parameter logic [11:0] T2            = DEF_T2,
    parameter logic [11:0] T3            = DEF_T3,
    parameter int unsigned HYST          = DEF_HYST,
    parameter logic [31:0] DIV0          = DEF_DIV0,
    parameter logic [31:0] DIV1          = DEF_DIV1,
    parameter logic [31:0] DIV2          = DEF_DIV2,
    parameter logic [31:0] DIV3          = DEF_DIV3
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        temp_valid,
    input  logic [11:0] temp_in,
    input  logic        tach_in,
    output logic [31:0] divider_out,
    output logic        divider_load,
    output logic [1:0]  speed_level,
    output logic        fan_fault,
    output logic [1:0]  state_out
);

    // Cycle counts are assumed to be at least one.
    localparam logic [31:0] SPINUP_LAST = 32'(SPINUP_CYCLES - 1);
    localparam logic [31:0] STALL_LAST  = 32'(STALL_CYCLES - 1);
    localparam logic [31:0] WINDOW_LAST = 32'(TACH_WINDOW - 1);
    localparam logic [31:0] TACH_MIN_W  = 32'(TACH_MIN);

    fan_state_t            r_state;
    fan_state_t            w_state_nxt;
    level_t                r_level;
    level_t                w_level_nxt;
    logic [31:0]           r_divider;
    logic [31:0]           w_divider_nxt;
    logic [31:0]           r_dwell;
    logic [31:0]           w_dwell_nxt;
    logic [31:0]           r_win;
    logic [31:0]           w_win_nxt;
    logic                  r_load;
    logic                  r_fault;
    logic                  w_fault_nxt;
    logic                  w_tach_clear;
    logic                  w_tach_enable;
    logic                  w_count_ok;
    logic [TACH_CNT_W-1:0] w_tach_count;

    function automatic logic [31:0] level_div(input level_t lvl);
        case (lvl)
            2'd0:    return DIV0;
            2'd1:    return DIV1;
            2'd2:    return DIV2;
            default: return DIV3;
        endcase
    endfunction

    assign w_tach_enable = (r_state == ST_RUN);
    assign w_count_ok    = ({{(32-TACH_CNT_W){1'b0}}, w_tach_count} >= TACH_MIN_W);

    tach_counter #(
        .CNT_W (TACH_CNT_W)
    ) u_tach (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .i_tach   (tach_in),
        .i_enable (w_tach_enable),
        .i_clear  (w_tach_clear),
        .o_count  (w_tach_count)
    );

    // One dwell counter serves SPINUP and STALL; the window counter is held at zero
    // outside RUN so every RUN entry starts a fresh window.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        w_state_nxt  = r_state;
        w_dwell_nxt  = r_dwell + 32'd1;
        w_win_nxt    = '0;
        w_fault_nxt  = r_fault;
        w_tach_clear = 1'b1;
        case (r_state)
            ST_SPINUP: begin
                if (r_dwell == SPINUP_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_dwell_nxt = '0;
                end
            end
            ST_RUN: begin
                w_dwell_nxt = '0;
                if (r_win == WINDOW_LAST) begin
                    if (w_count_ok) begin
                        w_fault_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_STALL;
                        w_fault_nxt = 1'b1;
                    end
                end else begin
                    w_win_nxt    = r_win + 32'd1;
                    w_tach_clear = 1'b0;
                end
            end
            ST_STALL: begin
                if (r_dwell == STALL_LAST) begin
                    w_state_nxt = ST_SPINUP;
                    w_dwell_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_SPINUP;
                w_dwell_nxt = '0;
            end
        endcase

        w_level_nxt   = temp_valid ? step_level(r_level, temp_in, T1, T2, T3, 13'(HYST))
                                   : r_level;
        w_divider_nxt = (w_state_nxt == ST_RUN) ? level_div(w_level_nxt) : DIV3;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= ST_SPINUP;
            r_level   <= '0;
            r_divider <= DIV3;
            r_load    <= 1'b0;
            r_fault   <= 1'b0;
            r_dwell   <= '0;
            r_win     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_level   <= w_level_nxt;
            r_divider <= w_divider_nxt;
            r_load    <= (w_divider_nxt != r_divider);
            r_fault   <= w_fault_nxt;
            r_dwell   <= w_dwell_nxt;
            r_win     <= w_win_nxt;
        end
    end

    assign divider_out  = r_divider;
    assign divider_load = r_load;
    assign speed_level  = r_level;
    assign fan_fault    = r_fault;
    assign state_out    = r_state;

endmodule

// File: tb/tb_fan_speed_sequencer.sv
// Self-checking bench for fan_speed_sequencer: directed vectors and sequences with
// hand-derived expectations, plus randomized traffic against a cycle-level reference model.
module tb_fan_speed_sequencer;

    localparam int SPIN  = 10;
    localparam int WIN   = 100;
    localparam int TMIN  = 2;
    localparam int STALL = 50;
    localparam int HYST  = 16;

    int thr  [4] = '{0, 'h900, 'hA00, 'hB00};
    int divs [4] = '{5000, 2500, 1250, 0};

    logic        clk_in     = 1'b0;
    logic        rst_n_in   = 1'b0;
    logic        temp_valid = 1'b0;
    logic [11:0] temp_in    = '0;
    logic        tach_in    = 1'b0;
    logic [31:0] divider_out;
    logic        divider_load;
    logic [1:0]  speed_level;
    logic        fan_fault;
    logic [1:0]  state_out;

    fan_speed_sequencer #(
        .SPINUP_CYCLES (SPIN),
        .TACH_WINDOW   (WIN),
        .TACH_MIN      (TMIN),
        .STALL_CYCLES  (STALL)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .temp_valid   (temp_valid),
        .temp_in      (temp_in),
        .tach_in      (tach_in),
        .divider_out  (divider_out),
        .divider_load (divider_load),
        .speed_level  (speed_level),
        .fan_fault    (fan_fault),
        .state_out    (state_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: countdown dwell timers, window counter and a tach delay line.
    int m_state, m_left, m_win, m_edges, m_level, m_fault, m_div, m_load;
    bit hist [3];
    bit cmp_en = 1'b0;

    function automatic void model_reset();
        m_state = 0; m_left = SPIN; m_win = 0; m_edges = 0;
        m_level = 0; m_fault = 0; m_div = divs[3]; m_load = 0;
        hist[0] = 1'b0; hist[1] = 1'b0; hist[2] = 1'b0;
    endfunction

    function automatic int model_level(input int level, input int temp);
        if (level < 3 && temp >= thr[level+1]) return level + 1;
        if (level > 0 && temp + HYST < thr[level]) return level - 1;
        return level;
    endfunction

    function automatic void model_step();
        int ev, nxt_level, nxt_div;
        ev = (hist[1] && !hist[2]) ? 1 : 0;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = tach_in;
        nxt_level = temp_valid ? model_level(m_level, int'(temp_in)) : m_level;
        case (m_state)
            0: begin
                m_left--;
                if (m_left == 0) begin m_state = 1; m_win = 0; m_edges = 0; end
            end
            1: begin
                if (m_win == WIN - 1) begin
                    if (m_edges < TMIN) begin m_state = 2; m_left = STALL; m_fault = 1; end
                    else m_fault = 0;
                    m_edges = ev;
                    m_win = 0;
                end else begin
                    m_win++;
                    m_edges = (m_edges + ev > 255) ? 255 : m_edges + ev;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin m_state = 0; m_left = SPIN; end
            end
        endcase
        m_level = nxt_level;
        nxt_div = (m_state == 1) ? divs[m_level] : divs[3];
        m_load  = (nxt_div != m_div) ? 1 : 0;
        m_div   = nxt_div;
    endfunction

    always @(negedge rst_n_in) model_reset();
    always @(posedge clk_in) if (rst_n_in) model_step();

    always @(negedge clk_in) begin
        if (rst_n_in && cmp_en) begin
            check("mdl_state", state_out,    m_state);
            check("mdl_level", speed_level,  m_level);
            check("mdl_div",   divider_out,  m_div);
            check("mdl_load",  divider_load, m_load);
            check("mdl_fault", fan_fault,    m_fault);
        end
    end

    int tach_half = 0;
    initial begin
        int ph = 0;
        forever begin
            @(negedge clk_in);
            if (tach_half != 0) begin
                ph++;
                if (ph >= tach_half) begin ph = 0; tach_in = ~tach_in; end
            end
        end
    end

    task automatic wait_state(input logic [1:0] st, input int budget);
        int n = 0;
        while (state_out !== st && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check("wait_state", state_out, st);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, state_out,    0);
        check({tag, "_div"},   divider_out,  divs[3]);
        check({tag, "_load"},  divider_load, 0);
        check({tag, "_level"}, speed_level,  0);
        check({tag, "_fault"}, fan_fault,    0);
    endtask

    task automatic check_spinup_then_run(input string tag, input int run_div);
        for (int i = 1; i <= SPIN - 1; i++) begin
            @(negedge clk_in);
            check({tag, "_spin_state"}, state_out, 0);
            check({tag, "_spin_div"},   divider_out, divs[3]);
        end
        @(negedge clk_in);
        check({tag, "_run_state"}, state_out, 1);
        check({tag, "_run_div"},   divider_out, run_div);
        check({tag, "_run_load"},  divider_load, 1);
        @(negedge clk_in);
        check({tag, "_load_low"},  divider_load, 0);
    endtask

    typedef struct {
        logic [11:0] temp;
        logic [1:0]  level;
        logic [31:0] div;
        logic        load;
    } vec_t;

    vec_t vecs [13];
    int   halves [6] = '{0, 1, 2, 4, 10, 40};

    initial begin
        vecs[0]  = '{12'h950, 2'd1, 32'd2500, 1'b1};
        vecs[1]  = '{12'hB10, 2'd2, 32'd1250, 1'b1};
        vecs[2]  = '{12'hB10, 2'd3, 32'd0,    1'b1};
        vecs[3]  = '{12'hFFF, 2'd3, 32'd0,    1'b0};
        vecs[4]  = '{12'hAF0, 2'd3, 32'd0,    1'b0};
        vecs[5]  = '{12'hAEF, 2'd2, 32'd1250, 1'b1};
        vecs[6]  = '{12'h9F0, 2'd2, 32'd1250, 1'b0};
        vecs[7]  = '{12'h9EF, 2'd1, 32'd2500, 1'b1};
        vecs[8]  = '{12'h8F5, 2'd1, 32'd2500, 1'b0};
        vecs[9]  = '{12'h8EF, 2'd0, 32'd5000, 1'b1};
        vecs[10] = '{12'h000, 2'd0, 32'd5000, 1'b0};
        vecs[11] = '{12'h8FF, 2'd0, 32'd5000, 1'b0};
        vecs[12] = '{12'h900, 2'd1, 32'd2500, 1'b1};

        model_reset();
        cmp_en    = 1'b1;
        tach_half = 10;
        repeat (3) @(negedge clk_in);
        check_reset_outputs("rst");
        rst_n_in = 1'b1;
        check_spinup_then_run("boot", divs[0]);

        // Threshold and hysteresis table, applied in RUN with a healthy tach.
        for (int v = 0; v < 13; v++) begin
            @(negedge clk_in);
            temp_valid = 1'b1;
            temp_in    = vecs[v].temp;
            @(negedge clk_in);
            temp_valid = 1'b0;
            check($sformatf("vec%0d_level", v), speed_level,  vecs[v].level);
            check($sformatf("vec%0d_div", v),   divider_out,  vecs[v].div);
            check($sformatf("vec%0d_load", v),  divider_load, vecs[v].load);
            @(negedge clk_in);
            check($sformatf("vec%0d_load_low", v), divider_load, 0);
        end

        // Tach stops: stall, level tracked during the dwell, re-spinup.
        tach_half = 0;
        @(negedge clk_in);
        tach_in = 1'b0;
        wait_state(2'd2, 300);
        check("stall_fault", fan_fault, 1);
        check("stall_div",   divider_out, divs[3]);
        check("stall_load",  divider_load, 1);
        for (int i = 1; i <= STALL - 1; i++) begin
            @(negedge clk_in);
            temp_valid = (i == 10);
            temp_in    = 12'hB10;
            check("stall_hold", state_out, 2);
            if (i == 11) begin
                check("stall_track_level", speed_level, 2);
                check("stall_track_div",   divider_out, divs[3]);
                check("stall_track_load",  divider_load, 0);
            end
        end
        @(negedge clk_in);
        check("stall_exit_state", state_out, 0);
        check("spin_fault_kept",  fan_fault, 1);
        check_spinup_then_run("respin", divs[2]);

        // Single tach pulse in a window fails it; a level change lands on the same edge.
        for (int i = 2; i <= WIN - 1; i++) begin
            @(negedge clk_in);
            tach_in    = (i >= 20 && i < 24);
            temp_valid = (i == WIN - 1);
            temp_in    = 12'h800;
            check("one_edge_run", state_out, 1);
        end
        @(negedge clk_in);
        temp_valid = 1'b0;
        check("one_edge_state", state_out, 2);
        check("one_edge_fault", fan_fault, 1);
        check("coinc_level",    speed_level, 1);
        check("coinc_div",      divider_out, divs[3]);
        check("coinc_load",     divider_load, 1);

        // Healthy tach after the stall clears the fault at the first window end.
        tach_half = 10;
        wait_state(2'd1, 100);
        check("recover_entry_div", divider_out, divs[1]);
        for (int i = 1; i <= WIN - 1; i++) begin
            @(negedge clk_in);
            if (i == WIN - 1) check("recover_fault_before", fan_fault, 1);
        end
        @(negedge clk_in);
        check("recover_fault", fan_fault, 0);
        check("recover_state", state_out, 1);

        // Asynchronous reset in the middle of a window at level 2.
        @(negedge clk_in);
        temp_valid = 1'b1;
        temp_in    = 12'hB10;
        @(negedge clk_in);
        temp_valid = 1'b0;
        check("pre_rst_level", speed_level, 2);
        check("pre_rst_div",   divider_out, divs[2]);
        repeat (30) @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1 check_reset_outputs("async_rst");
        repeat (2) @(negedge clk_in);
        check("rst_held_state", state_out, 0);
        rst_n_in = 1'b1;
        check_spinup_then_run("post_rst", divs[0]);

        // Randomized traffic checked every cycle by the model.
        for (int blk = 0; blk < 40; blk++) begin
            tach_half = halves[$urandom_range(5)];
            for (int c = 0; c < 150; c++) begin
                @(negedge clk_in);
                temp_valid = ($urandom_range(3) == 0);
                temp_in    = ($urandom_range(3) == 0) ? 12'($urandom)
                                                      : 12'($urandom_range(32'h8C0, 32'hB40));
            end
            if ($urandom_range(7) == 0) begin
                #2 rst_n_in = 1'b0;
                #1 check("rnd_rst_state", state_out, 0);
                check("rnd_rst_div", divider_out, divs[3]);
                @(negedge clk_in);
                rst_n_in = 1'b1;
            end
        end

        @(negedge clk_in);
        temp_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
